// File: rtl/mips_pipe_pkg.sv
//------------------------------------------------------------------------------
// mips_pipe_pkg: shared encodings for the MIPS pipeline hazard controller.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mips_pipe_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // Youngest producer wins; r0 is hard-wired and never forwarded.
    function automatic logic [1:0] fwd_select(
        input logic [4:0] src,
        input logic       used,
        input logic       ex_en,
        input logic [4:0] ex_dest,
        input logic       mem_en,
        input logic [4:0] mem_dest,
        input logic       wb_en,
        input logic [4:0] wb_dest
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (used && (src != REG_ZERO)) begin
            if (ex_en && (ex_dest == src))
                sel = FWD_EX;
            else if (mem_en && (mem_dest == src))
                sel = FWD_MEM;
            else if (wb_en && (wb_dest == src))
                sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_seq.sv
//------------------------------------------------------------------------------
// muldiv_seq: latency sequencer for the multi-cycle MULT/DIV unit.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module muldiv_seq
    import mips_pipe_pkg::*;
#(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic is_div,
    input  logic accept,
    output logic busy,
    output logic hilo_we
);

    localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int CW      = $clog2(MAX_LAT) + 1;

    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_LAT - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_LAT - 1);

    md_state_t     state;
    logic [CW-1:0] count;
    logic [CW-1:0] load_val;

    assign load_val = is_div ? DIV_LOAD : MULT_LOAD;

    // hilo_we is registered a cycle early so it lines up with count reaching zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= MD_IDLE;
            count   <= '0;
            busy    <= 1'b0;
            hilo_we <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start && accept) begin
                        state   <= MD_BUSY;
                        count   <= load_val;
                        busy    <= 1'b1;
                        hilo_we <= (load_val == '0);
                    end
                end
                MD_BUSY: begin
                    if (count == '0) begin
                        state   <= MD_IDLE;
                        busy    <= 1'b0;
                        hilo_we <= 1'b0;
                    end else begin
                        count   <= count - 1'b1;
                        hilo_we <= (count == CW'(1));
                    end
                end
                default: begin
                    state   <= MD_IDLE;
                    busy    <= 1'b0;
                    hilo_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
//------------------------------------------------------------------------------
// pipeline_hazard_ctrl: forwarding, load-use/HI-LO stalls and MULT/DIV sequencing.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipeline_hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 12,
    parameter int CNT_W    = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [4:0]       ID_RS,
    input  logic [4:0]       ID_RT,
    input  logic             ID_USES_RS,
    input  logic             ID_USES_RT,
    input  logic             ID_MULDIV_START,
    input  logic             ID_MULDIV_IS_DIV,
    input  logic             ID_READS_HILO,
    input  logic [4:0]       EX_DEST,
    input  logic             EX_RF_ENABLE,
    input  logic             EX_LOAD_INSTR,
    input  logic [4:0]       MEM_DEST,
    input  logic             MEM_RF_ENABLE,
    input  logic [4:0]       WB_DEST,
    input  logic             WB_RF_ENABLE,
    output logic             PC_LE,
    output logic             IF_ID_LE,
    output logic             ID_EX_BUBBLE,
    output logic [1:0]       FWD_A_SEL,
    output logic [1:0]       FWD_B_SEL,
    output logic             MULDIV_BUSY,
    output logic             HILO_WE,
    output logic [CNT_W-1:0] STALL_CNT
);

    logic       load_use;
    logic       hilo_stall;
    logic       stall;
    logic       md_accept;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    assign fwd_a = fwd_select(ID_RS, ID_USES_RS, EX_RF_ENABLE, EX_DEST,
                              MEM_RF_ENABLE, MEM_DEST, WB_RF_ENABLE, WB_DEST);
    assign fwd_b = fwd_select(ID_RT, ID_USES_RT, EX_RF_ENABLE, EX_DEST,
                              MEM_RF_ENABLE, MEM_DEST, WB_RF_ENABLE, WB_DEST);

    assign load_use = EX_LOAD_INSTR && EX_RF_ENABLE && (EX_DEST != REG_ZERO) &&
                      ((ID_USES_RS && (ID_RS == EX_DEST)) ||
                       (ID_USES_RT && (ID_RT == EX_DEST)));

    assign hilo_stall = MULDIV_BUSY && (ID_READS_HILO || ID_MULDIV_START);
    assign stall      = load_use || hilo_stall;
    assign md_accept  = ID_MULDIV_START && !stall;

    // Reset forces the pipeline-facing outputs combinationally, not just at the next edge.
    assign PC_LE        = Reset && !stall;
    assign IF_ID_LE     = Reset && !stall;
    assign ID_EX_BUBBLE = !Reset || stall;
    assign FWD_A_SEL    = Reset ? fwd_a : FWD_RF;
    assign FWD_B_SEL    = Reset ? fwd_b : FWD_RF;

    muldiv_seq #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_muldiv_seq (
        .clk     (Clk),
        .rst_n   (Reset),
        .start   (ID_MULDIV_START),
        .is_div  (ID_MULDIV_IS_DIV),
        .accept  (md_accept),
        .busy    (MULDIV_BUSY),
        .hilo_we (HILO_WE)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            STALL_CNT <= '0;
        else if (stall && (STALL_CNT != {CNT_W{1'b1}}))
            STALL_CNT <= STALL_CNT + 1'b1;
    end

endmodule

`default_nettype wire
